// File: rtl/md_pkg.sv
// Shared op-code encoding and classification helpers for the HI/LO multiply/divide unit.
package md_pkg;

  localparam int MD_OP_W = 4;

  localparam logic [MD_OP_W-1:0] MD_NONE  = 4'd0;
  localparam logic [MD_OP_W-1:0] MD_MULT  = 4'd1;
  localparam logic [MD_OP_W-1:0] MD_MULTU = 4'd2;
  localparam logic [MD_OP_W-1:0] MD_DIV   = 4'd3;
  localparam logic [MD_OP_W-1:0] MD_DIVU  = 4'd4;
  localparam logic [MD_OP_W-1:0] MD_MTHI  = 4'd5;
  localparam logic [MD_OP_W-1:0] MD_MTLO  = 4'd6;
  localparam logic [MD_OP_W-1:0] MD_MADD  = 4'd7;
  localparam logic [MD_OP_W-1:0] MD_MADDU = 4'd8;
  localparam logic [MD_OP_W-1:0] MD_MSUB  = 4'd9;
  localparam logic [MD_OP_W-1:0] MD_MSUBU = 4'd10;

  function automatic logic md_is_mul(input logic [MD_OP_W-1:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic md_is_div(input logic [MD_OP_W-1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_acc(input logic [MD_OP_W-1:0] op);
    return (op == MD_MADD) || (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
  endfunction

  function automatic logic md_is_move(input logic [MD_OP_W-1:0] op);
    return (op == MD_MTHI) || (op == MD_MTLO);
  endfunction

  // Counter must hold the larger latency minus one; never narrower than one bit.
  function automatic int md_cnt_w(input int lat_a, input int lat_b);
    int lat_max;
    lat_max = (lat_a > lat_b) ? lat_a : lat_b;
    return (lat_max > 1) ? $clog2(lat_max) : 1;
  endfunction

endpackage

// File: rtl/md_unit_param_if.sv
// E-stage <-> MD unit signal bundle: decoded op and operands in, HI/LO and hazard flags out.
interface md_unit_param_if
  import md_pkg::*;
#(
  parameter int WIDTH = 32
);
  logic [MD_OP_W-1:0] op;
  logic [WIDTH-1:0]   D1;
  logic [WIDTH-1:0]   D2;
  logic               exc_int;
  logic [WIDTH-1:0]   HI;
  logic [WIDTH-1:0]   LO;
  logic               start;
  logic               busy;

  modport master (output op, D1, D2, exc_int, input HI, LO, start, busy);
  modport slave  (input op, D1, D2, exc_int, output HI, LO, start, busy);
endinterface

// File: rtl/md_lat_ctr.sv
// Loadable latency down-counter; busy spans exactly load_val+1 cycles, done marks the final one.
module md_lat_ctr #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             busy,
  output logic             done
);
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      busy <= 1'b0;
    end else if (load) begin
      cnt  <= load_val;
      busy <= 1'b1;
    end else if (busy) begin
      if (cnt == '0) busy <= 1'b0;
      else           cnt  <= cnt - CNT_W'(1);
    end
  end

  assign done = busy && (cnt == '0);
endmodule

// File: rtl/md_unit_param.sv
// Parametrised HI/LO multiply/divide unit; result is computed at issue and committed after the op latency.
// Build option MD_MADD_EN adds MADD/MADDU/MSUB/MSUBU accumulate ops.
module md_unit_param
  import md_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input logic            clk,
  input logic            reset,
  md_unit_param_if.slave bus
);
  localparam int CNT_W = md_cnt_w(MUL_LAT, DIV_LAT);
  localparam int W2    = 2 * WIDTH;

  logic [WIDTH-1:0] d1, d2, hi_q, lo_q;
  logic [W2-1:0]    prod_s, prod_u, result, pend_q;
  logic             pend_we;
  logic             op_mult, op_div, op_divu, op_mul_any, op_div_any, op_acc;
  logic             op_mthi, op_mtlo, issue_ok, accept, busy, done;
  logic             div_zero;
  logic [WIDTH-1:0] div_den, q_u, r_u, mag1, mag2, q_m, r_m, q_s, r_s;
  logic [CNT_W-1:0] lat_load;

  assign d1 = bus.D1;
  assign d2 = bus.D2;

  assign op_mult    = (bus.op == MD_MULT);
  assign op_div     = (bus.op == MD_DIV);
  assign op_divu    = (bus.op == MD_DIVU);
  assign op_mul_any = md_is_mul(bus.op);
  assign op_div_any = md_is_div(bus.op);
  assign op_mthi    = (bus.op == MD_MTHI);
  assign op_mtlo    = (bus.op == MD_MTLO);
`ifdef MD_MADD_EN
  assign op_acc     = md_is_acc(bus.op);
`else
  assign op_acc     = 1'b0;
`endif

  assign issue_ok  = !bus.exc_int && !busy;
  assign accept    = issue_ok && (op_mul_any || op_div_any || op_acc);
  assign bus.start = accept && !reset;
  assign bus.busy  = busy;
  assign bus.HI    = hi_q;
  assign bus.LO    = lo_q;

  // Sign-extending to 2*WIDTH lets one unsigned multiplier produce the signed product.
  assign prod_s = {{WIDTH{d1[WIDTH-1]}}, d1} * {{WIDTH{d2[WIDTH-1]}}, d2};
  assign prod_u = {{WIDTH{1'b0}}, d1} * {{WIDTH{1'b0}}, d2};

  // Divisor is steered to 1 on zero so the datapath never divides by zero; commit is suppressed instead.
  assign div_zero = (d2 == '0);
  assign div_den  = div_zero ? WIDTH'(1) : d2;
  assign q_u      = d1 / div_den;
  assign r_u      = d1 % div_den;

  // Signed divide on magnitudes; MIN/-1 falls out as MIN with zero remainder.
  assign mag1 = d1[WIDTH-1] ? -d1 : d1;
  assign mag2 = d2[WIDTH-1] ? -d2 : div_den;
  assign q_m  = mag1 / mag2;
  assign r_m  = mag1 % mag2;
  assign q_s  = (d1[WIDTH-1] ^ d2[WIDTH-1]) ? -q_m : q_m;
  assign r_s  = d1[WIDTH-1] ? -r_m : r_m;

`ifdef MD_MADD_EN
  logic [W2-1:0] hilo, acc_prod;
  assign hilo     = {hi_q, lo_q};
  assign acc_prod = ((bus.op == MD_MADD) || (bus.op == MD_MSUB)) ? prod_s : prod_u;
`endif

  always_comb begin
    result = prod_u;
    if (op_mult)      result = prod_s;
    else if (op_div)  result = {r_s, q_s};
    else if (op_divu) result = {r_u, q_u};
`ifdef MD_MADD_EN
    else if (op_acc) begin
      if ((bus.op == MD_MSUB) || (bus.op == MD_MSUBU)) result = hilo - acc_prod;
      else                                             result = hilo + acc_prod;
    end
`endif
  end

  assign lat_load = op_div_any ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);

  md_lat_ctr #(.CNT_W(CNT_W)) u_lat_ctr (
    .clk     (clk),
    .reset   (reset),
    .load    (accept),
    .load_val(lat_load),
    .busy    (busy),
    .done    (done)
  );

  // done requires busy and moves/issue require !busy, so these updates never collide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q    <= '0;
      lo_q    <= '0;
      pend_q  <= '0;
      pend_we <= 1'b0;
    end else begin
      if (accept) begin
        pend_q  <= result;
        pend_we <= !(op_div_any && div_zero);
      end
      if (done && pend_we) {hi_q, lo_q} <= pend_q;
      if (issue_ok && op_mthi) hi_q <= d1;
      if (issue_ok && op_mtlo) lo_q <= d1;
    end
  end
endmodule

// File: tb/tb_md_unit_param.sv
// Self-checking bench for md_unit_param against a 64-bit arithmetic reference model.
module tb_md_unit_param;
  import md_pkg::*;

  localparam int WIDTH   = 32;
  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [31:0] mhi = '0;
  logic [31:0] mlo = '0;

  md_unit_param_if #(.WIDTH(WIDTH)) bus ();

  md_unit_param #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic void model_eval(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                     input logic [31:0] hi, input logic [31:0] lo,
                                     output bit multi, output bit mvh, output bit mvl, output int lat,
                                     output logic [31:0] nh, output logic [31:0] nl, output bit we);
    longint sa, sb, q, r;
    longint unsigned ua, ub, p, acc;
    sa = longint'(int'(a)); sb = longint'(int'(b));
    ua = longint'(a);       ub = longint'(b);
    acc = {hi, lo};
    multi = 0; mvh = 0; mvl = 0; lat = 0; nh = hi; nl = lo; we = 1;
    case (o)
      MD_MULT:  begin multi = 1; lat = MUL_LAT; p = sa * sb; {nh, nl} = p; end
      MD_MULTU: begin multi = 1; lat = MUL_LAT; p = ua * ub; {nh, nl} = p; end
      MD_DIV: begin
        multi = 1; lat = DIV_LAT;
        if (b == 0) we = 0;
        else begin q = sa / sb; r = sa % sb; nl = q[31:0]; nh = r[31:0]; end
      end
      MD_DIVU: begin
        multi = 1; lat = DIV_LAT;
        if (b == 0) we = 0;
        else begin nl = a / b; nh = a % b; end
      end
      MD_MTHI: begin mvh = 1; nh = a; end
      MD_MTLO: begin mvl = 1; nl = a; end
`ifdef MD_MADD_EN
      MD_MADD:  begin multi = 1; lat = MUL_LAT; p = sa * sb; {nh, nl} = acc + p; end
      MD_MADDU: begin multi = 1; lat = MUL_LAT; p = ua * ub; {nh, nl} = acc + p; end
      MD_MSUB:  begin multi = 1; lat = MUL_LAT; p = sa * sb; {nh, nl} = acc - p; end
      MD_MSUBU: begin multi = 1; lat = MUL_LAT; p = ua * ub; {nh, nl} = acc - p; end
`endif
      default: ;
    endcase
  endfunction

  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input bit x);
    bit multi, mvh, mvl, we, exp_start;
    int lat;
    logic [31:0] nh, nl;
    model_eval(o, a, b, mhi, mlo, multi, mvh, mvl, lat, nh, nl, we);
    exp_start = multi && !x;
    @(negedge clk);
    bus.op = o; bus.D1 = a; bus.D2 = b; bus.exc_int = x;
    #1;
    n_cmp++;
    if (bus.start !== exp_start) begin
      n_bad++;
      $display("FAIL start op=%0d exc=%0b actual=%b expected=%b", o, x, bus.start, exp_start);
    end
    @(posedge clk); #1;
    bus.op = MD_NONE; bus.exc_int = 1'b0;
    if (exp_start) begin
      for (int i = 0; i < lat; i++) begin
        @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b1 || bus.HI !== mhi || bus.LO !== mlo) begin
          n_bad++;
          $display("FAIL busy_hold op=%0d cyc=%0d actual busy=%b HI=%h LO=%h expected busy=1 HI=%h LO=%h",
                   o, i, bus.busy, bus.HI, bus.LO, mhi, mlo);
        end
      end
      if (we) begin mhi = nh; mlo = nl; end
    end else if (!x) begin
      if (mvh) mhi = nh;
      if (mvl) mlo = nl;
    end
    @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.HI !== mhi || bus.LO !== mlo) begin
      n_bad++;
      $display("FAIL result op=%0d a=%h b=%h actual busy=%b HI=%h LO=%h expected busy=0 HI=%h LO=%h",
               o, a, b, bus.busy, bus.HI, bus.LO, mhi, mlo);
    end
  endtask

  task automatic test_reset();
    bus.op = MD_MULT; bus.D1 = 32'd3; bus.D2 = 32'd4; bus.exc_int = 1'b0;
    #12;
    n_cmp++;
    if (bus.start !== 1'b0 || bus.busy !== 1'b0 || bus.HI !== 32'd0 || bus.LO !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_state actual start=%b busy=%b HI=%h LO=%h expected 0/0/0/0",
               bus.start, bus.busy, bus.HI, bus.LO);
    end
    @(negedge clk);
    bus.op = MD_NONE;
    reset = 1'b0;
    mhi = '0; mlo = '0;
  endtask

  task automatic test_mult();
    issue(MD_MULT, 32'hFFFFFFFD, 32'd7, 1'b0);
    n_cmp++;
    if (bus.HI !== 32'hFFFFFFFF || bus.LO !== 32'hFFFFFFEB) begin
      n_bad++;
      $display("FAIL mult_neg3x7 actual HI=%h LO=%h expected FFFFFFFF/FFFFFFEB", bus.HI, bus.LO);
    end
    issue(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
  endtask

  task automatic test_div();
    issue(MD_DIVU, 32'd100, 32'd7, 1'b0);
    n_cmp++;
    if (bus.HI !== 32'd2 || bus.LO !== 32'd14) begin
      n_bad++;
      $display("FAIL divu_100_7 actual HI=%h LO=%h expected 2/14", bus.HI, bus.LO);
    end
    issue(MD_DIV, 32'hFFFFFFF9, 32'd2, 1'b0);
    n_cmp++;
    if (bus.HI !== 32'hFFFFFFFF || bus.LO !== 32'hFFFFFFFD) begin
      n_bad++;
      $display("FAIL div_m7_2 actual HI=%h LO=%h expected FFFFFFFF/FFFFFFFD", bus.HI, bus.LO);
    end
    issue(MD_DIV, 32'd12345, 32'd0, 1'b0);
    n_cmp++;
    if (bus.HI !== 32'hFFFFFFFF || bus.LO !== 32'hFFFFFFFD) begin
      n_bad++;
      $display("FAIL div_by_zero actual HI=%h LO=%h expected unchanged FFFFFFFF/FFFFFFFD", bus.HI, bus.LO);
    end
    issue(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    n_cmp++;
    if (bus.HI !== 32'd0 || bus.LO !== 32'h80000000) begin
      n_bad++;
      $display("FAIL div_min_m1 actual HI=%h LO=%h expected 0/80000000", bus.HI, bus.LO);
    end
    issue(MD_DIVU, 32'h80000000, 32'd0, 1'b0);
  endtask

  task automatic test_exc_and_guard();
    bit multi, mvh, mvl, we;
    int lat;
    logic [31:0] nh, nl;
    issue(MD_MULT, 32'd2, 32'd3, 1'b1);
    model_eval(MD_DIV, 32'd50, 32'd6, mhi, mlo, multi, mvh, mvl, lat, nh, nl, we);
    @(negedge clk);
    bus.op = MD_DIV; bus.D1 = 32'd50; bus.D2 = 32'd6;
    @(posedge clk); #1;
    bus.op = MD_MULT; bus.D1 = 32'd2; bus.D2 = 32'd3; bus.exc_int = 1'b1;
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      if (i == 2) bus.exc_int = 1'b0;
      #1;
      n_cmp++;
      if (bus.start !== 1'b0 || bus.busy !== 1'b1 || bus.HI !== mhi || bus.LO !== mlo) begin
        n_bad++;
        $display("FAIL guard_busy cyc=%0d actual start=%b busy=%b HI=%h LO=%h expected 0/1/%h/%h",
                 i, bus.start, bus.busy, bus.HI, bus.LO, mhi, mlo);
      end
      if (i == lat - 1) bus.op = MD_NONE;
    end
    mhi = nh; mlo = nl;
    @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.HI !== 32'd2 || bus.LO !== 32'd8) begin
      n_bad++;
      $display("FAIL guard_commit actual busy=%b HI=%h LO=%h expected 0/2/8", bus.busy, bus.HI, bus.LO);
    end
  endtask

  task automatic test_move();
    issue(MD_MTHI, 32'h12345678, 32'd0, 1'b0);
    n_cmp++;
    if (bus.HI !== 32'h12345678) begin
      n_bad++;
      $display("FAIL mthi actual HI=%h expected 12345678", bus.HI);
    end
    issue(MD_MTLO, 32'hA5A5A5A5, 32'd0, 1'b0);
    n_cmp++;
    if (bus.LO !== 32'hA5A5A5A5 || bus.HI !== 32'h12345678) begin
      n_bad++;
      $display("FAIL mtlo actual HI=%h LO=%h expected 12345678/A5A5A5A5", bus.HI, bus.LO);
    end
    issue(MD_MTHI, 32'hDEADBEEF, 32'd0, 1'b1);
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    bus.op = MD_DIV; bus.D1 = 32'd1000; bus.D2 = 32'd3;
    @(posedge clk); #1;
    bus.op = MD_NONE;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    mhi = '0; mlo = '0;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.HI !== 32'd0 || bus.LO !== 32'd0) begin
      n_bad++;
      $display("FAIL async_reset actual busy=%b HI=%h LO=%h expected 0/0/0", bus.busy, bus.HI, bus.LO);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < DIV_LAT + 2; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.busy !== 1'b0 || bus.HI !== 32'd0 || bus.LO !== 32'd0) begin
        n_bad++;
        $display("FAIL stale_commit cyc=%0d actual busy=%b HI=%h LO=%h expected 0/0/0",
                 i, bus.busy, bus.HI, bus.LO);
      end
    end
    issue(MD_MULT, 32'd9, 32'd11, 1'b0);
  endtask

  task automatic test_madd();
    logic [31:0] hi0, lo0;
    issue(MD_MTHI, 32'd0, 32'd0, 1'b0);
    issue(MD_MTLO, 32'hFFFFFFFF, 32'd0, 1'b0);
    hi0 = mhi; lo0 = mlo;
    issue(MD_MADDU, 32'd1, 32'd1, 1'b0);
`ifdef MD_MADD_EN
    n_cmp++;
    if (bus.HI !== 32'd1 || bus.LO !== 32'd0) begin
      n_bad++;
      $display("FAIL maddu actual HI=%h LO=%h expected 1/0", bus.HI, bus.LO);
    end
    issue(MD_MSUB, 32'd1, 32'd1, 1'b0);
    n_cmp++;
    if (bus.HI !== 32'd0 || bus.LO !== 32'hFFFFFFFF) begin
      n_bad++;
      $display("FAIL msub actual HI=%h LO=%h expected 0/FFFFFFFF", bus.HI, bus.LO);
    end
    issue(MD_MADD, 32'hFFFFFFFE, 32'd3, 1'b0);
    issue(MD_MSUBU, 32'hFFFFFFFF, 32'd2, 1'b0);
`else
    n_cmp++;
    if (bus.HI !== hi0 || bus.LO !== lo0) begin
      n_bad++;
      $display("FAIL maddu_disabled actual HI=%h LO=%h expected %h/%h", bus.HI, bus.LO, hi0, lo0);
    end
    issue(MD_MSUB, 32'd5, 32'd5, 1'b0);
`endif
  endtask

  task automatic test_random();
    logic [3:0]  o;
    logic [31:0] a, b;
    bit x;
    for (int n = 0; n < 60; n++) begin
      o = 4'($urandom_range(0, 15));
      a = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1, 2:    b = 32'($urandom_range(1, 20));
        3:       b = 32'hFFFFFFFF - 32'($urandom_range(0, 3));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 15) == 0) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
      x = ($urandom_range(0, 7) == 0);
      issue(o, a, b, x);
    end
  endtask

  initial begin
    bus.op = MD_NONE; bus.D1 = '0; bus.D2 = '0; bus.exc_int = 1'b0;
    test_reset();
    test_mult();
    test_div();
    test_exc_and_guard();
    test_move();
    test_reset_mid_op();
    test_madd();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/md_unit_param.md
Name: md_unit_param

Overview:
- Parametrised multiply/divide unit for the E stage of the pipelined MIPS datapath; next generation of the fixed 32-bit MD block.
- Accepts one decoded HI/LO operation per issue and runs it for a configurable multi-cycle latency.
- Commits results to the HI/LO registers at completion.
- Exports start/busy so the hazard unit can stall dependent instructions, and honours exception/interrupt flush at issue.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MUL_LAT, 5, busy cycles for MULT/MULTU (and MADD family); must be >=1.
- DIV_LAT, 10, busy cycles for DIV/DIVU; must be >=1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- op  in  4  decoded operation code from md_pkg; MD_NONE when the E-stage instruction is not an MD op.
- D1  in  WIDTH  rs operand (forwarded).
- D2  in  WIDTH  rt operand (forwarded).
- exc_int  in  1  exception/interrupt taken this cycle; the E-stage op must not issue.
- HI  out  WIDTH  HI register.
- LO  out  WIDTH  LO register.
- start  out  1  combinational; a multi-cycle op is accepted this cycle.
- busy  out  1  registered; a multi-cycle op is in flight.

Behaviour:
- Reset (asynchronous, active-high): HI=0, LO=0, busy=0, counter=0, pending result cleared. start is forced to 0 while reset is high.
- Accept condition = op is a multi-cycle op && !exc_int && !busy. start equals the accept condition.
- Issue on an accept edge:
  - Operands are captured and the result is computed into pending registers.
  - Counter loads LAT-1 and busy becomes 1.
- While busy, the counter decrements each edge. On the edge where the counter reads 0, HI/LO take the pending result and busy falls.
- Result timing:
  - busy is high for exactly LAT cycles after the issue edge.
  - New HI/LO are visible in the first cycle busy=0.
  - No HI/LO change is visible before then.
- MTHI/MTLO:
  - Single-cycle; accepted when !exc_int && !busy.
  - Write D1 to HI or LO on that edge; start and busy stay 0.
- Any op presented while busy=1 is ignored: no start, no state change. Upstream stalls on start||busy, so this is a guard, not a normal case.
- exc_int has no effect on an op already in flight; it completes and commits (MIPS semantics).
- Arithmetic:
  - MULT: signed 2*WIDTH product, {HI,LO}=product.
  - MULTU: unsigned 2*WIDTH product.
  - DIV: signed; LO=quotient truncated toward zero, HI=remainder with the dividend's sign. MIN/-1 gives LO=MIN, HI=0 (two's-complement wrap).
  - DIVU: unsigned.
  - Divide by zero: runs the full DIV_LAT, and HI/LO are left unchanged at commit.
- Undefined op codes behave as MD_NONE.
- Implementation may compute iteratively (e.g. a restoring divider) provided latency and results match exactly.

Optional Feature:
- Macro: MD_MADD_EN.
- Defined: adds MADD, MADDU, MSUB, MSUBU. Each computes {HI,LO} ± (D1*D2), signed or unsigned, modulo 2^(2*WIDTH), with MUL_LAT latency. The accumulator base is the HI/LO value at issue; this is safe because HI/LO cannot change while busy.
- Undefined: those four codes decode as MD_NONE (no start, no effect).

Decomposition:
- Package md_pkg:
  - MD_OP_W=4.
  - Op-code constants: MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO, MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU.
  - Helper constants classifying mul vs div vs move.
- Sub-module md_lat_ctr:
  - Loadable down-counter with busy flag.
  - Counter width $clog2(max(MUL_LAT,DIV_LAT)).
  - Ports: load, load value, busy, done pulse.

Test Plan (WIDTH=32, MUL_LAT=5, DIV_LAT=10):
- MULT D1=0xFFFFFFFD (-3), D2=7 -> start=1 for one cycle, busy=1 for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFEB; HI/LO at their prior values until busy falls.
- DIVU 100/7 -> busy 10 cycles, LO=14, HI=2. Then DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then DIV x/0 -> busy 10 cycles, HI/LO unchanged.
- MULT presented with exc_int=1 -> start=0, busy stays 0, HI/LO unchanged. Then MULT 2*3 presented while a DIV is busy -> ignored; DIV result commits.
- MTHI D1=0x12345678 while idle -> HI=0x12345678 next edge, start=0, busy=0. Then MTLO D1=0xA5A5A5A5 -> LO=0xA5A5A5A5.
- Reset asserted asynchronously in cycle 3 of a DIV -> busy=0, HI=LO=0 immediately. After release, no stale commit occurs and a new MULT issues normally.
- With MD_MADD_EN: HI=0, LO=0xFFFFFFFF, MADDU 1*1 -> after 5 cycles HI=1, LO=0. Then MSUB 1*1 -> HI=0, LO=0xFFFFFFFF. Without the macro, op=MD_MADDU -> start=0, no change.
